// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, MIPS funct codes and the UART front-end states.
package alu_pkg;

  localparam int unsigned DEF_N_BITS_DATA = 32;
  localparam int unsigned DEF_N_BITS_OP   = 6;
  localparam int unsigned DEF_N_BITS_BYTE = 8;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_XOR = 6'b100110;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;
  localparam logic [5:0] FUNCT_SRA = 6'b000011;

  typedef enum logic [2:0] {
    RX_D1   = 3'd0,
    RX_D2   = 3'd1,
    RX_OP   = 3'd2,
    EXEC    = 3'd3,
    TX_SEND = 3'd4,
    TX_WAIT = 3'd5
  } state_e;

endpackage

// File: rtl/alu_uart_interface.sv
// UART front end for the ALU: gathers operand/opcode bytes, drives the ALU,
// and streams the result back LSB first over a start/done handshake.
module alu_uart_interface
  import alu_pkg::*;
#(
  parameter int unsigned N_BITS_DATA = DEF_N_BITS_DATA,
  parameter int unsigned N_BITS_OP   = DEF_N_BITS_OP,
  parameter int unsigned N_BITS_BYTE = DEF_N_BITS_BYTE
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_rx_done,
  input  logic [N_BITS_BYTE-1:0] i_rx_data,
  input  logic                   i_tx_done,
  output logic                   o_tx_start,
  output logic [N_BITS_BYTE-1:0] o_tx_data,
  output logic [N_BITS_DATA-1:0] o_data_1,
  output logic [N_BITS_DATA-1:0] o_data_2,
  output logic [N_BITS_OP-1:0]   o_ctrl,
  input  logic [N_BITS_DATA-1:0] i_alu_result,
  output logic                   o_busy
);

  localparam int unsigned NB    = N_BITS_DATA / N_BITS_BYTE;
  localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [N_BITS_DATA-1:0] data1_q, data1_d;
  logic [N_BITS_DATA-1:0] data2_q, data2_d;
  logic [N_BITS_OP-1:0]   ctrl_q, ctrl_d;
  logic [N_BITS_DATA-1:0] result_q, result_d;
  logic [N_BITS_BYTE-1:0] tx_data_q, tx_data_d;
  logic                   tx_start_q, tx_start_d;
  logic                   busy_q, busy_d;

  // State, byte index and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= RX_D1;
      idx_q      <= '0;
      data1_q    <= '0;
      data2_q    <= '0;
      ctrl_q     <= '0;
      result_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      data1_q    <= data1_d;
      data2_q    <= data2_d;
      ctrl_q     <= ctrl_d;
      result_q   <= result_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
    end
  end

  // Next state and byte index; each event only acts in the state that owns it.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      RX_D1: begin
        if (i_rx_done) begin
          if (idx_q == IDX_LAST) begin
            state_d = RX_D2;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      RX_D2: begin
        if (i_rx_done) begin
          if (idx_q == IDX_LAST) begin
            state_d = RX_OP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      RX_OP: begin
        if (i_rx_done) begin
          state_d = EXEC;
          idx_d   = '0;
        end
      end
      EXEC: begin
        state_d = TX_SEND;
        idx_d   = '0;
      end
      TX_SEND: begin
        state_d = TX_WAIT;
      end
      TX_WAIT: begin
        if (i_tx_done) begin
          if (idx_q == IDX_LAST) begin
            state_d = RX_D1;
            idx_d   = '0;
          end else begin
            state_d = TX_SEND;
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = RX_D1;
        idx_d   = '0;
      end
    endcase
  end

  // Register updates for operands, opcode, result and transmit side.
  always_comb begin
    data1_d    = data1_q;
    data2_d    = data2_q;
    ctrl_d     = ctrl_q;
    result_d   = result_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = 1'b0;

    case (state_q)
      RX_D1:   if (i_rx_done) data1_d[N_BITS_BYTE*32'(idx_q) +: N_BITS_BYTE] = i_rx_data;
      RX_D2:   if (i_rx_done) data2_d[N_BITS_BYTE*32'(idx_q) +: N_BITS_BYTE] = i_rx_data;
      RX_OP:   if (i_rx_done) ctrl_d = i_rx_data[N_BITS_OP-1:0];
      EXEC:    result_d = i_alu_result;
      default: ;
    endcase

    // Entering TX_SEND from EXEC the result register is loading this edge,
    // so byte 0 is taken straight from the ALU.
    if (state_d == TX_SEND) begin
      tx_start_d = 1'b1;
      if (state_q == EXEC) begin
        tx_data_d = i_alu_result[N_BITS_BYTE-1:0];
      end else begin
        tx_data_d = result_q[N_BITS_BYTE*32'(idx_d) +: N_BITS_BYTE];
      end
    end

    busy_d = (state_d == EXEC) || (state_d == TX_SEND) || (state_d == TX_WAIT);
  end

  assign o_data_1   = data1_q;
  assign o_data_2   = data2_q;
  assign o_ctrl     = ctrl_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed bench: behavioural ALU and UART transmitter around alu_uart_interface.
module tb_alu_uart_interface;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic        rx_done;
  logic [7:0]  rx_data;
  logic        tx_done;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [31:0] data_1;
  logic [31:0] data_2;
  logic [5:0]  ctrl;
  logic [31:0] alu_res;
  logic        busy;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] tx_q[$];
  int         start_cnt = 0;
  int         tx_delay  = 1;

  alu_uart_interface dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_rx_done    (rx_done),
    .i_rx_data    (rx_data),
    .i_tx_done    (tx_done),
    .o_tx_start   (tx_start),
    .o_tx_data    (tx_data),
    .o_data_1     (data_1),
    .o_data_2     (data_2),
    .o_ctrl       (ctrl),
    .i_alu_result (alu_res),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU on the registered operands.
  always_comb begin
    case (ctrl)
      FUNCT_ADD: alu_res = data_1 + data_2;
      FUNCT_SUB: alu_res = data_1 - data_2;
      FUNCT_AND: alu_res = data_1 & data_2;
      FUNCT_OR:  alu_res = data_1 | data_2;
      FUNCT_XOR: alu_res = data_1 ^ data_2;
      FUNCT_NOR: alu_res = ~(data_1 | data_2);
      FUNCT_SRL: alu_res = data_1 >> data_2[4:0];
      FUNCT_SRA: alu_res = 32'($signed(data_1) >>> data_2[4:0]);
      default:   alu_res = 32'h0;
    endcase
  end

  // UART transmitter model: captures each started byte, answers after tx_delay cycles.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (tx_start === 1'b1) begin
        tx_q.push_back(tx_data);
        start_cnt++;
        repeat (tx_delay + 1) @(negedge clk);
        tx_done = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] t;
      t = w >> (8 * i);
      send_byte(t[7:0]);
    end
  endtask

  task automatic send_frame(input logic [31:0] d1, input logic [31:0] d2, input logic [7:0] op);
    send_word(d1);
    send_word(d2);
    send_byte(op);
  endtask

  // Waits (bounded) for four transmitted bytes and the return to idle, then checks them.
  task automatic expect_frame(input string tag, input logic [31:0] exp, input int budget);
    logic [31:0] got;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (tx_q.size() >= 4 && busy === 1'b0) break;
    end
    check({tag, "_nbytes"}, 32'(tx_q.size()), 32'd4);
    got = 32'h0;
    for (int i = 0; i < 4 && i < tx_q.size(); i++) got = got | (32'(tx_q[i]) << (8 * i));
    check({tag, "_result"}, got, exp);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    tx_q.delete();
  endtask

  initial begin
    rst     = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_data1", data_1, 32'h0);
    check("rst_data2", data_2, 32'h0);
    check("rst_ctrl", 32'(ctrl), 32'h0);
    check("rst_txdata", 32'(tx_data), 32'h0);
    check("rst_txstart", 32'(tx_start), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // ADD 3 + 2, with latency to first tx_start
    tx_delay = 1;
    start_cnt = 0;
    send_word(32'h0000_0003);
    send_word(32'h0000_0002);
    check("add_no_early_start", 32'(start_cnt), 32'd0);
    send_byte(8'h20);
    check("add_exec_busy", 32'(busy), 32'd1);
    check("add_exec_nostart", 32'(tx_start), 32'd0);
    check("add_ctrl", 32'(ctrl), 32'h20);
    @(negedge clk);
    check("add_latency_start", 32'(tx_start), 32'd1);
    check("add_first_byte", 32'(tx_data), 32'h05);
    expect_frame("add", 32'h0000_0005, 200);
    check("add_data1", data_1, 32'h0000_0003);
    check("add_data2", data_2, 32'h0000_0002);
    check("add_starts", 32'(start_cnt), 32'd4);

    // SRA with stalled transmitter
    tx_delay = 50;
    start_cnt = 0;
    send_frame(32'hDFFF_FFFB, 32'h0000_0003, 8'h03);
    expect_frame("sra", 32'hFBFF_FFFF, 1000);
    check("sra_starts", 32'(start_cnt), 32'd4);
    check("sra_data1", data_1, 32'hDFFF_FFFB);

    // NOR with opcode upper bits set
    tx_delay = 1;
    send_frame(32'h0000_0003, 32'h0000_0002, 8'hE7);
    check("nor_ctrl", 32'(ctrl), 32'h27);
    expect_frame("nor", 32'hFFFF_FFFC, 200);

    // rx pulses during TX_WAIT must be dropped
    tx_delay = 20;
    start_cnt = 0;
    send_frame(32'h0F0F_0F0F, 32'h00FF_00FF, 8'h24);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (start_cnt >= 1) break;
    end
    check("inj_started", 32'(start_cnt), 32'd1);
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(8'hAA);
    check("inj_busy", 32'(busy), 32'd1);
    check("inj_data1", data_1, 32'h0F0F_0F0F);
    check("inj_data2", data_2, 32'h00FF_00FF);
    check("inj_ctrl", 32'(ctrl), 32'h24);
    expect_frame("and", 32'h000F_000F, 400);
    tx_delay = 1;
    send_frame(32'h0000_0003, 32'h0000_0002, 8'h22);
    expect_frame("sub", 32'h0000_0001, 200);

    // Reset after 5 received bytes
    start_cnt = 0;
    send_word(32'h4433_2211);
    send_byte(8'h77);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_data1", data_1, 32'h0);
    check("mid_rst_data2", data_2, 32'h0);
    check("mid_rst_ctrl", 32'(ctrl), 32'h0);
    check("mid_rst_txdata", 32'(tx_data), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    send_word(32'h0000_0003);
    send_word(32'h0000_0002);
    check("post_rst_no_start", 32'(start_cnt), 32'd0);
    send_byte(8'h20);
    expect_frame("post_rst_add", 32'h0000_0005, 200);
    check("post_rst_starts", 32'(start_cnt), 32'd4);

    // Back-to-back SRL then OR
    send_frame(32'h0000_00FF, 32'h0000_0003, 8'h02);
    expect_frame("srl", 32'h0000_001F, 200);
    send_frame(32'h0000_0003, 32'h0000_0002, 8'h25);
    check("or_ctrl", 32'(ctrl), 32'h25);
    expect_frame("or", 32'h0000_0003, 200);
    check("or_data1", data_1, 32'h0000_0003);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
